// File: rtl/instr_trip_persist.sv
// Instrumentation trip unit: per-channel setpoint compare, persistence filter and latched trip.
// Optional macro INSTR_TRIP_AUTOCLEAR_EN: latches self-clear after Persist non-tripping samples.
module instr_trip_chan #(
  parameter int   Width   = 32,
  parameter int   Persist = 4,
  parameter logic Low     = 1'b0,
  parameter logic Sgn     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [Width-1:0] v,
  input  logic [Width-1:0] sp,
  input  logic [1:0]       mode,
  input  logic             trip_reset,
  output logic             raw_trip,
  output logic             trip_d,
  output logic             trip_out
);
  localparam int CW = $clog2(Persist + 1);
  localparam logic [CW-1:0] PMAX = CW'(Persist);

  logic lt, gt, cmp, trip_smp;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic lat, lat_d;

  assign lt       = Sgn ? ($signed(v) < $signed(sp)) : (v < sp);
  assign gt       = Sgn ? ($signed(sp) < $signed(v)) : (sp < v);
  assign cmp      = Low ? lt : gt;
  assign trip_smp = sample_valid & cmp;
  assign cnt_inc  = (cnt == PMAX) ? PMAX : cnt + CW'(1);

`ifdef INSTR_TRIP_AUTOCLEAR_EN
  logic [CW-1:0] clr, clr_d, clr_inc;
  assign clr_inc = (clr == PMAX) ? PMAX : clr + CW'(1);
`endif

  always_comb begin
    cnt_d = cnt;
    lat_d = lat;
`ifdef INSTR_TRIP_AUTOCLEAR_EN
    clr_d = clr;
`endif
    if (mode == 2'd0) begin
      cnt_d = '0;
      lat_d = 1'b0;
`ifdef INSTR_TRIP_AUTOCLEAR_EN
      clr_d = '0;
`endif
    end else begin
      if (trip_smp) begin
        cnt_d = cnt_inc;
        if (cnt_inc == PMAX) lat_d = 1'b1;
      end else if (sample_valid) begin
        cnt_d = '0;
      end
`ifdef INSTR_TRIP_AUTOCLEAR_EN
      if (trip_smp) clr_d = '0;
      else if (sample_valid) begin
        clr_d = clr_inc;
        if (clr_inc == PMAX) lat_d = 1'b0;
      end
`else
      // a trip in the same cycle wins over the operator clear
      if (trip_reset && !raw_trip && !trip_smp) lat_d = 1'b0;
`endif
    end
    case (mode)
      2'd0:    trip_d = 1'b0;
      2'd1:    trip_d = lat_d;
      default: trip_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_trip <= 1'b0;
      trip_out <= 1'b0;
      cnt      <= '0;
      lat      <= 1'b0;
`ifdef INSTR_TRIP_AUTOCLEAR_EN
      clr      <= '0;
`endif
    end else begin
      if (sample_valid) raw_trip <= cmp;
      trip_out <= trip_d;
      cnt      <= cnt_d;
      lat      <= lat_d;
`ifdef INSTR_TRIP_AUTOCLEAR_EN
      clr      <= clr_d;
`endif
    end
  end

`ifdef INSTR_TRIP_AUTOCLEAR_EN
  logic unused_reset;
  assign unused_reset = trip_reset;
`endif
endmodule

module instr_trip_persist #(
  parameter int NChannels = 3,
  parameter int Width     = 32,
  parameter int Persist   = 4,
  parameter logic [NChannels-1:0] LowTripMask = 3'b100,
  parameter logic [NChannels-1:0] SignedMask  = 3'b100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [NChannels*Width-1:0] vals,
  input  logic [NChannels*Width-1:0] setpoints,
  input  logic [NChannels*2-1:0]     mode,
  input  logic                       trip_reset,
  output logic [NChannels-1:0]       raw_trip,
  output logic [NChannels-1:0]       trip_out,
  output logic                       any_trip
);
  logic [NChannels-1:0] trip_d;

  for (genvar c = 0; c < NChannels; c++) begin : g_ch
    instr_trip_chan #(
      .Width(Width), .Persist(Persist),
      .Low(LowTripMask[c]), .Sgn(SignedMask[c])
    ) u_ch (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .v(vals[c*Width +: Width]), .sp(setpoints[c*Width +: Width]),
      .mode(mode[c*2 +: 2]), .trip_reset(trip_reset),
      .raw_trip(raw_trip[c]), .trip_d(trip_d[c]), .trip_out(trip_out[c])
    );
  end

  // registered from next-state trips so it lines up with trip_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_trip <= 1'b0;
    else     any_trip <= |trip_d;
  end
endmodule

// File: tb/tb_instr_trip_persist.sv
// Scoreboard bench for instr_trip_persist (default parameters): behavioural model plus directed checks.
module tb_instr_trip_persist;
  localparam int N = 3, W = 32, P = 4;
  localparam logic [2:0] LOWM = 3'b100, SGNM = 3'b100;

  logic clk = 0, rst = 1, sample_valid = 0, trip_reset = 0;
  logic [N*W-1:0] vals, setpoints;
  logic [N*2-1:0] mode;
  logic [N-1:0] raw_trip, trip_out;
  logic any_trip;

  instr_trip_persist dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .vals(vals),
    .setpoints(setpoints), .mode(mode), .trip_reset(trip_reset),
    .raw_trip(raw_trip), .trip_out(trip_out), .any_trip(any_trip)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] raw; logic [2:0] trip; logic any; } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  logic [W-1:0] v[N], s[N];
  logic [1:0] m[N];
  int mcnt[N], mclr[N];
  bit mlat[N], mraw[N], mtrip[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cmp_of(int c);
    bit lt, gt;
    if (SGNM[c]) begin
      lt = $signed(v[c]) < $signed(s[c]);
      gt = $signed(s[c]) < $signed(v[c]);
    end else begin
      lt = v[c] < s[c];
      gt = s[c] < v[c];
    end
    return LOWM[c] ? lt : gt;
  endfunction

  task automatic step(input logic sv, input logic trst, input logic r);
    exp_t e;
    bit cm, ts, old_raw;
    @(negedge clk);
    rst = r; sample_valid = sv; trip_reset = trst;
    for (int c = 0; c < N; c++) begin
      vals[c*W +: W] = v[c];
      setpoints[c*W +: W] = s[c];
      mode[c*2 +: 2] = m[c];
    end
    for (int c = 0; c < N; c++) begin
      if (r) begin
        mcnt[c] = 0; mclr[c] = 0; mlat[c] = 0; mraw[c] = 0; mtrip[c] = 0;
        continue;
      end
      cm = cmp_of(c);
      ts = sv && cm;
      old_raw = mraw[c];
      if (sv) mraw[c] = cm;
      if (m[c] == 0) begin
        mcnt[c] = 0; mlat[c] = 0; mclr[c] = 0;
      end else begin
        if (ts) begin
          mcnt[c] = (mcnt[c] < P) ? mcnt[c] + 1 : P;
          if (mcnt[c] == P) mlat[c] = 1;
          mclr[c] = 0;
        end else if (sv) begin
          mcnt[c] = 0;
`ifdef INSTR_TRIP_AUTOCLEAR_EN
          mclr[c] = (mclr[c] < P) ? mclr[c] + 1 : P;
          if (mclr[c] == P) mlat[c] = 0;
`endif
        end
`ifndef INSTR_TRIP_AUTOCLEAR_EN
        if (trst && !old_raw && !ts) mlat[c] = 0;
`endif
      end
      mtrip[c] = (m[c] == 0) ? 1'b0 : (m[c] == 1) ? mlat[c] : 1'b1;
    end
    for (int c = 0; c < N; c++) begin
      e.raw[c] = mraw[c];
      e.trip[c] = mtrip[c];
    end
    e.any = |e.trip;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("raw_trip", {29'd0, raw_trip}, {29'd0, e.raw});
    chk("trip_out", {29'd0, trip_out}, {29'd0, e.trip});
    chk("any_trip", {31'd0, any_trip}, {31'd0, e.any});
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      v[c] = 0; s[c] = 0; m[c] = 2'd1;
    end
    vals = '0; setpoints = '0; mode = '0;

    // 1: reset holds everything low even with tripping inputs
    v[0] = 101; s[0] = 100;
    repeat (3) begin
      step(1, 0, 1);
      chk("rst_trip", {29'd0, trip_out}, 0);
      chk("rst_raw", {29'd0, raw_trip}, 0);
    end

    // 2: persistence, equality breaks the run
    repeat (3) step(1, 0, 0);
    v[0] = 100; step(1, 0, 0);
    chk("eq_raw0", {31'd0, raw_trip[0]}, 0);
    v[0] = 101;
    repeat (3) step(1, 0, 0);
    chk("p3_trip0", {31'd0, trip_out[0]}, 0);
    step(1, 0, 0);
    chk("p4_trip0", {31'd0, trip_out[0]}, 1);
    chk("p4_any", {31'd0, any_trip}, 1);

    // 4: trip blocks clear; clear works after non-tripping sample
    step(1, 1, 0);
    chk("blk_clr0", {31'd0, trip_out[0]}, 1);
    v[0] = 50; step(1, 0, 0);
    step(0, 1, 0);
`ifdef INSTR_TRIP_AUTOCLEAR_EN
    chk("clr_trip0", {31'd0, trip_out[0]}, 1);
    repeat (3) step(1, 0, 0);
    chk("aclr_trip0", {31'd0, trip_out[0]}, 0);
`else
    chk("clr_trip0", {31'd0, trip_out[0]}, 0);
`endif

    // 5: modes on ch1
    m[1] = 2'd2; step(1, 0, 0);
    chk("man_trip1", {31'd0, trip_out[1]}, 1);
    m[1] = 2'd3; step(1, 0, 0);
    chk("rsv_trip1", {31'd0, trip_out[1]}, 1);
    m[1] = 2'd1; step(1, 0, 0);
    chk("op_trip1", {31'd0, trip_out[1]}, 0);
    v[1] = 5;
    repeat (4) step(1, 0, 0);
    chk("lat_trip1", {31'd0, trip_out[1]}, 1);
    m[1] = 2'd0; step(1, 0, 0);
    chk("byp_trip1", {31'd0, trip_out[1]}, 0);
    m[1] = 2'd1;
    repeat (3) step(1, 0, 0);
    chk("ret_trip1", {31'd0, trip_out[1]}, 0);
    step(1, 0, 0);
    chk("ret4_trip1", {31'd0, trip_out[1]}, 1);

    // 3: signed low trip on ch2, unsigned high trip on ch1
    m[1] = 2'd0; step(1, 0, 0);
    m[1] = 2'd1;
    v[1] = 32'hFFFF_FFFF; s[1] = 0;
    v[2] = 32'hFFFF_FFFF; s[2] = 0;
    repeat (4) step(1, 0, 0);
    chk("sgn_trip2", {31'd0, trip_out[2]}, 1);
    chk("uns_trip1", {31'd0, trip_out[1]}, 1);
    m[1] = 2'd0; step(1, 0, 0);
    m[1] = 2'd1; v[1] = 0; s[1] = 32'hFFFF_FFFF;
    repeat (4) step(1, 0, 0);
    chk("uns_no1", {31'd0, trip_out[1]}, 0);
    chk("uns_raw1", {31'd0, raw_trip[1]}, 0);
    v[2] = 1; step(1, 0, 0);
    chk("sgn_raw2", {31'd0, raw_trip[2]}, 0);

    // mid-sequence reset discards partial count; then valid gaps hold the count
    m[2] = 2'd0; step(1, 0, 0);
    m[2] = 2'd1; v[2] = 0; s[2] = 0; v[1] = 0; s[1] = 0;
    v[0] = 101; s[0] = 100;
    repeat (2) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    chk("gap6_trip0", {31'd0, trip_out[0]}, 0);
    step(1, 0, 0);
    chk("gap7_trip0", {31'd0, trip_out[0]}, 1);
    v[0] = 50;
    repeat (4) step(1, 0, 0);
`ifdef INSTR_TRIP_AUTOCLEAR_EN
    chk("auto_trip0", {31'd0, trip_out[0]}, 0);
`else
    chk("hold_trip0", {31'd0, trip_out[0]}, 1);
    step(0, 1, 0);
    chk("opclr_trip0", {31'd0, trip_out[0]}, 0);
`endif
    chk("end_any", {31'd0, any_trip}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_trip_persist.md
Name: instr_trip_persist

Overview:
- Parametrised next-generation instrumentation trip unit: per-channel setpoint comparison, configurable comparison direction and signedness, plus persistence filtering and latched trip outputs.
- Sits between sensor sampling and voting logic.
- Replaces the fixed three-channel combinational compare and mode decode with a registered, debounced, operator-resettable trip per channel.

Parameters:
NChannels, 3, number of instrumentation channels (>=1)
Width, 32, bits per sensor value and per setpoint
Persist, 4, consecutive tripping valid samples required to latch a trip (>=1)
LowTripMask, 3'b100, bit c=1: channel c trips when value < setpoint; bit c=0: trips when setpoint < value
SignedMask, 3'b100, bit c=1: channel c compare is two's-complement signed; bit c=0: unsigned

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
sample_valid  in  1  vals/setpoints valid this cycle
vals  in  NChannels*Width  sensor values; channel c at [c*Width +: Width]
setpoints  in  NChannels*Width  setpoints; same packing as vals
mode  in  NChannels*2  per-channel mode at [c*2 +: 2]: 0 bypass, 1 operate, 2 manual trip, 3 reserved
trip_reset  in  1  operator reset pulse for latched trips
raw_trip  out  NChannels  registered raw compare result of last valid sample
trip_out  out  NChannels  registered, filtered channel trip
any_trip  out  1  OR of trip_out, registered with trip_out

Behaviour:
- Reset (async, rst=1): raw_trip=0, trip_out=0, any_trip=0, all persistence counters=0, all latches=0. The block operates normally from the first clk edge after rst deasserts.
- Compare, per channel c, combinational on the inputs:
  - LowTripMask[c]=1: cmp = v < sp; LowTripMask[c]=0: cmp = sp < v.
  - Signedness is selected by SignedMask[c].
  - Equality never trips.
- Sampling: on a clk edge with sample_valid=1, raw_trip[c] <= cmp. With sample_valid=0, raw_trip holds.
- Persistence counter, per channel, width $clog2(Persist+1), saturating at Persist:
  - sample_valid & cmp: cnt <= min(cnt+1, Persist).
  - sample_valid & !cmp: cnt <= 0.
  - No valid sample: cnt holds.
- Latch set: when the incremented count equals Persist, latch[c] <= 1.
  - trip_out rises at the clk edge of the Persist-th consecutive tripping valid sample; registered result visible the following cycle.
  - Persist=1 gives single-sample latency.
- Latch clear: trip_reset=1 clears latch[c] only if raw_trip[c]=0, i.e. the last valid sample was non-tripping, and no tripping valid sample arrives in the same cycle.
  - A simultaneous tripping sample blocks the clear; trip has priority.
  - The counter is not affected by trip_reset.
- Mode, sampled every cycle:
  - 0 bypass: counter and latch forced to 0; trip_out[c] <= 0.
  - 1 operate: trip_out[c] <= latch[c] next value.
  - 2 manual trip: trip_out[c] <= 1 regardless of compare. Counter and latch continue normally.
  - 3 reserved: treated as 2 (fail-safe).
- Leaving bypass starts from cnt=0 and an unlatched state. Leaving manual trip leaves trip_out equal to the latch.
- any_trip <= OR of the next trip_out values, so it is cycle-aligned with trip_out.
- Asserting rst mid-sequence discards partial counts and latches immediately.

Optional Feature:
INSTR_TRIP_AUTOCLEAR_EN
- Defined: latches self-clear after Persist consecutive non-tripping valid samples, using a second saturating clear counter per channel that is zeroed by any tripping sample. trip_reset is ignored.
- Undefined: trips stay latched until trip_reset as specified above; no clear counters are instantiated.

Test Plan:
1. Reset value: hold rst=1 for 3 cycles with mode=1 and tripping inputs -> trip_out=0, any_trip=0, raw_trip=0 throughout.
2. Persistence: Persist=4, ch0 unsigned high trip, sp=100, v=101 on 4 consecutive valid samples -> trip_out[0]=1 the cycle after the 4th sample. Inserting v=100 (equal) after the 3rd sample resets the count, so trip_out[0] stays 0 until 4 more trips.
3. Signed low trip: ch2 sp=0, v=32'hFFFF_FFFF (-1) for 4 valid samples -> trip_out[2]=1. Same stimulus on ch1 (unsigned high trip, sp=0) -> trip_out[1]=1; sp=32'hFFFF_FFFF, v=0 on ch1 -> no trip.
4. Reset rules: ch0 latched, then trip_reset together with a tripping sample -> stays 1. Then a non-tripping sample, then trip_reset -> trip_out[0]=0 next cycle.
5. Modes: ch1 mode=2 with non-tripping inputs -> trip_out[1]=1 next cycle. mode=3 -> 1. mode=0 while latched -> 0. Return to mode=1 -> 0 until Persist new tripping samples.
6. sample_valid gaps: alternate sample_valid 1/0 with v tripping, Persist=4 -> trip after the 4th valid sample (cycle 7), counts hold across gaps. With INSTR_TRIP_AUTOCLEAR_EN: after latch, 4 non-tripping samples -> trip_out clears with no trip_reset.
